alu_ctrl_decoder: RTL and testbench



---
 rtl/alu_ctrl_decoder.sv | 166 ++++++++++++++++
 tb/tb_alu_ctrl_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_decoder.sv
// RV64I decode stage: instruction word -> ALU control, immediate and operand select,
// registered behind a valid/ready handshake with a 2-entry (main + skid) buffer.
module alu_ctrl_decoder (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] instr_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [3:0]  ALUCtrl_o,
    output logic [63:0] imm_o,
    output logic        use_imm_o,
    output logic        illegal_o
);

    typedef enum logic [3:0] {
        ALU_XOR     = 4'b0000,
        ALU_OR      = 4'b0001,
        ALU_ADD     = 4'b0010,
        ALU_AND     = 4'b0011,
        ALU_SLL     = 4'b0100,
        ALU_SRL     = 4'b0101,
        ALU_SUB     = 4'b0110,
        ALU_SRA     = 4'b0111,
        ALU_ILLEGAL = 4'b1111
    } alu_op_e;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_BRANCH = 7'b1100011
    } opcode_e;

    typedef struct packed {
        alu_op_e     alu;
        logic [63:0] imm;
        logic        use_imm;
        logic        illegal;
    } dec_t;

    localparam dec_t RESET_ENTRY = '{alu: ALU_ILLEGAL, imm: '0, use_imm: 1'b0, illegal: 1'b0};
    localparam dec_t ILLEGAL_ENTRY = '{alu: ALU_ILLEGAL, imm: '0, use_imm: 1'b0, illegal: 1'b1};

    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [5:0]  shift_hi;
    logic [63:0] imm_i_type;
    logic [63:0] imm_s_type;
    logic [63:0] imm_shamt;
    logic        unused_rs1;

    assign funct3     = instr_i[14:12];
    assign funct7     = instr_i[31:25];
    assign shift_hi   = instr_i[31:26];
    assign imm_i_type = {{52{instr_i[31]}}, instr_i[31:20]};
    assign imm_s_type = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_shamt  = {58'd0, instr_i[25:20]};
    assign unused_rs1 = ^instr_i[19:15];

    dec_t dec;
    logic bad;

    always_comb begin
        dec = '{alu: ALU_ADD, imm: '0, use_imm: 1'b0, illegal: 1'b0};
        bad = 1'b0;
        case (instr_i[6:0])
            OPC_OP: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  dec.alu = ALU_ADD;
                        3'b001:  dec.alu = ALU_SLL;
                        3'b100:  dec.alu = ALU_XOR;
                        3'b101:  dec.alu = ALU_SRL;
                        3'b110:  dec.alu = ALU_OR;
                        3'b111:  dec.alu = ALU_AND;
                        default: bad = 1'b1;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    case (funct3)
                        3'b000:  dec.alu = ALU_SUB;
                        3'b101:  dec.alu = ALU_SRA;
                        default: bad = 1'b1;
                    endcase
                end else begin
                    bad = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec.use_imm = 1'b1;
                dec.imm     = imm_i_type;
                case (funct3)
                    3'b000: dec.alu = ALU_ADD;
                    3'b100: dec.alu = ALU_XOR;
                    3'b110: dec.alu = ALU_OR;
                    3'b111: dec.alu = ALU_AND;
                    3'b001: begin
                        dec.imm = imm_shamt;
                        if (shift_hi == 6'b000000) dec.alu = ALU_SLL;
                        else bad = 1'b1;
                    end
                    3'b101: begin
                        dec.imm = imm_shamt;
                        if (shift_hi == 6'b000000) dec.alu = ALU_SRL;
                        else if (shift_hi == 6'b010000) dec.alu = ALU_SRA;
                        else bad = 1'b1;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.use_imm = 1'b1;
                dec.imm     = imm_i_type;
            end
            OPC_STORE: begin
                dec.use_imm = 1'b1;
                dec.imm     = imm_s_type;
            end
            OPC_BRANCH: dec.alu = ALU_SUB;
            default:    bad = 1'b1;
        endcase
        if (bad) dec = ILLEGAL_ENTRY;
    end

    dec_t main_q, skid_q;
    logic main_valid_q, skid_valid_q;

    // With the skid full ready_o is low, so no accept can coincide with a skid->main move.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= RESET_ENTRY;
            skid_q       <= RESET_ENTRY;
        end else if (flush_i) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (skid_valid_q) begin
            if (ready_i) begin
                main_q       <= skid_q;
                skid_valid_q <= 1'b0;
            end
        end else if (valid_i) begin
            if (!main_valid_q || ready_i) begin
                main_q       <= dec;
                main_valid_q <= 1'b1;
            end else begin
                skid_q       <= dec;
                skid_valid_q <= 1'b1;
            end
        end else if (ready_i) begin
            main_valid_q <= 1'b0;
        end
    end

    assign ready_o   = !skid_valid_q;
    assign valid_o   = main_valid_q;
    assign ALUCtrl_o = main_q.alu;
    assign imm_o     = main_q.imm;
    assign use_imm_o = main_q.use_imm;
    assign illegal_o = main_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Bench for alu_ctrl_decoder: directed decodes plus randomized handshake traffic
// checked against a queue-based transaction model.
module tb_alu_ctrl_decoder;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, valid_i, ready_i;
    logic [31:0] instr_i;
    logic        ready_o, valid_o, use_imm_o, illegal_o;
    logic [3:0]  ALUCtrl_o;
    logic [63:0] imm_o;

    alu_ctrl_decoder dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready_o), .instr_i(instr_i), .valid_o(valid_o), .ready_i(ready_i),
        .ALUCtrl_o(ALUCtrl_o), .imm_o(imm_o), .use_imm_o(use_imm_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0]  alu;
        logic [63:0] imm;
        logic        use_imm;
        logic        illegal;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   delivered = 0;

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t        e;
        longint      i_imm, s_imm;
        int unsigned op, f3, f7, hi6;
        op  = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        hi6 = w[31:26];
        i_imm = longint'(w[31:20]);
        if (w[31]) i_imm -= 4096;
        s_imm = longint'(w[31:25]) * 32 + longint'(w[11:7]);
        if (w[31]) s_imm -= 4096;
        e = '{alu: 4'hF, imm: 64'd0, use_imm: 1'b0, illegal: 1'b1};
        if (op == 'h33) begin
            if (f7 == 0 && f3 != 2 && f3 != 3) begin
                e.illegal = 1'b0;
                e.alu = (f3 == 0) ? 4'b0010 : (f3 == 1) ? 4'b0100 : (f3 == 4) ? 4'b0000 :
                        (f3 == 5) ? 4'b0101 : (f3 == 6) ? 4'b0001 : 4'b0011;
            end else if (f7 == 'h20 && (f3 == 0 || f3 == 5)) begin
                e.illegal = 1'b0;
                e.alu = (f3 == 0) ? 4'b0110 : 4'b0111;
            end
        end else if (op == 'h13) begin
            if (f3 == 0 || f3 == 4 || f3 == 6 || f3 == 7) begin
                e = '{alu: (f3 == 0) ? 4'b0010 : (f3 == 4) ? 4'b0000 : (f3 == 6) ? 4'b0001 : 4'b0011,
                      imm: 64'(i_imm), use_imm: 1'b1, illegal: 1'b0};
            end else if ((f3 == 1 && hi6 == 0) || (f3 == 5 && (hi6 == 0 || hi6 == 'h10))) begin
                e = '{alu: (f3 == 1) ? 4'b0100 : (hi6 == 0) ? 4'b0101 : 4'b0111,
                      imm: 64'(w[25:20]), use_imm: 1'b1, illegal: 1'b0};
            end
        end else if (op == 'h03) begin
            e = '{alu: 4'b0010, imm: 64'(i_imm), use_imm: 1'b1, illegal: 1'b0};
        end else if (op == 'h23) begin
            e = '{alu: 4'b0010, imm: 64'(s_imm), use_imm: 1'b1, illegal: 1'b0};
        end else if (op == 'h63) begin
            e = '{alu: 4'b0110, imm: 64'd0, use_imm: 1'b0, illegal: 1'b0};
        end
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int unsigned pick;
        w = $urandom;
        pick = $urandom_range(0, 2);
        case ($urandom_range(0, 7))
            0, 1: begin
                w[6:0] = 7'h33;
                if (pick == 0) w[31:25] = 7'h00;
                else if (pick == 1) w[31:25] = 7'h20;
            end
            2, 3: begin
                w[6:0] = 7'h13;
                if (w[13:12] == 2'b01) begin
                    if (pick == 0) w[31:26] = 6'h00;
                    else if (pick == 1) w[31:26] = 6'h10;
                end
            end
            4: w[6:0] = 7'h03;
            5: w[6:0] = 7'h23;
            6: w[6:0] = 7'h63;
            default: ;
        endcase
        return w;
    endfunction

    // Advance the transaction model by one cycle using the currently driven inputs.
    task automatic tick();
        bit   acc, pop;
        exp_t e;
        if (rst_i || flush_i) begin
            q.delete();
        end else begin
            acc = valid_i && (q.size() < 2);
            pop = (q.size() > 0) && ready_i;
            e   = ref_decode(instr_i);
            if (pop) begin
                void'(q.pop_front());
                delivered++;
            end
            if (acc) q.push_back(e);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({valid_o, ready_o, ALUCtrl_o, imm_o, use_imm_o, illegal_o} !== {1'b0, 1'b1, 4'hF, 64'd0, 1'b0, 1'b0}) begin
            $display("FAIL reset_values: got v=%b r=%b alu=%h imm=%h use=%b ill=%b, want v=0 r=1 alu=f imm=0 use=0 ill=0",
                     valid_o, ready_o, ALUCtrl_o, imm_o, use_imm_o, illegal_o);
        end else n_pass++;
    endtask

    task automatic test_directed();
        logic [31:0] ins [6];
        exp_t        want [6];
        exp_t        got;
        ins[0] = 32'h002081B3; want[0] = '{4'b0010, 64'd0, 1'b0, 1'b0};
        ins[1] = 32'h402081B3; want[1] = '{4'b0110, 64'd0, 1'b0, 1'b0};
        ins[2] = 32'hFFF00093; want[2] = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        ins[3] = 32'h43F35293; want[3] = '{4'b0111, 64'h3F, 1'b1, 1'b0};
        ins[4] = 32'h0020A423; want[4] = '{4'b0010, 64'h8, 1'b1, 1'b0};
        ins[5] = 32'h0020A1B3; want[5] = '{4'b1111, 64'd0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            valid_i = 1'b1; instr_i = ins[i]; ready_i = 1'b1;
            tick();
            valid_i = 1'b0;
            got = {ALUCtrl_o, imm_o, use_imm_o, illegal_o};
            n_checks++;
            if (valid_o !== 1'b1 || got !== want[i]) begin
                $display("FAIL directed_%0d instr=%h: got v=%b %h, want v=1 %h", i, ins[i], valid_o, got, want[i]);
            end else n_pass++;
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ins [4];
        int          idx = 0;
        bit          rdy_low_seen = 0;
        exp_t        got;
        ins[0] = 32'h002081B3; ins[1] = 32'hFFF00093; ins[2] = 32'h43F35293; ins[3] = 32'h0020A423;
        delivered = 0;
        for (int c = 1; c <= 10; c++) begin
            valid_i = (idx < 4);
            instr_i = ins[idx % 4];
            ready_i = !(c >= 2 && c <= 4);
            if (valid_i && q.size() < 2) idx++;
            tick();
            if (!ready_o) rdy_low_seen = 1;
            n_checks++;
            if (valid_o !== (q.size() > 0) || ready_o !== (q.size() < 2)) begin
                $display("FAIL bp_handshake c=%0d: got v=%b r=%b, want v=%b r=%b", c, valid_o, ready_o, q.size() > 0, q.size() < 2);
            end else n_pass++;
            if (q.size() > 0) begin
                got = {ALUCtrl_o, imm_o, use_imm_o, illegal_o};
                n_checks++;
                if (got !== q[0]) $display("FAIL bp_payload c=%0d: got %h, want %h", c, got, q[0]);
                else n_pass++;
            end
        end
        valid_i = 1'b0;
        n_checks++;
        if (delivered !== 4 || !rdy_low_seen) $display("FAIL bp_delivered: got %0d ready_low=%0d, want 4 ready_low=1", delivered, rdy_low_seen);
        else n_pass++;
    endtask

    task automatic test_random_stream();
        exp_t got;
        for (int c = 0; c < 600; c++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 59) == 0);
            instr_i = gen_instr();
            tick();
            n_checks++;
            if (valid_o !== (q.size() > 0) || ready_o !== (q.size() < 2)) begin
                $display("FAIL rand_handshake c=%0d: got v=%b r=%b, want v=%b r=%b", c, valid_o, ready_o, q.size() > 0, q.size() < 2);
            end else n_pass++;
            if (q.size() > 0) begin
                got = {ALUCtrl_o, imm_o, use_imm_o, illegal_o};
                n_checks++;
                if (got !== q[0]) $display("FAIL rand_payload c=%0d: got %h, want %h", c, got, q[0]);
                else n_pass++;
            end
        end
        flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        tick(); tick();
    endtask

    task automatic test_flush();
        ready_i = 1'b0; valid_i = 1'b1;
        instr_i = 32'h002081B3; tick();
        instr_i = 32'h402081B3; tick();
        n_checks++;
        if (valid_o !== 1'b1 || ready_o !== 1'b0) $display("FAIL flush_fill: got v=%b r=%b, want v=1 r=0", valid_o, ready_o);
        else n_pass++;
        flush_i = 1'b1; instr_i = 32'hFFF00093;
        tick();
        flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        n_checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) $display("FAIL flush_clear: got v=%b r=%b, want v=0 r=1", valid_o, ready_o);
        else n_pass++;
        tick();
        n_checks++;
        if (valid_o !== 1'b0) $display("FAIL flush_no_ghost: got v=%b, want v=0", valid_o);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        ready_i = 1'b0; valid_i = 1'b1;
        instr_i = 32'h0020A1B3; tick();
        instr_i = 32'hFFF00093; tick();
        n_checks++;
        if (valid_o !== 1'b1 || ready_o !== 1'b0) $display("FAIL rst_fill: got v=%b r=%b, want v=1 r=0", valid_o, ready_o);
        else n_pass++;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; valid_i = 1'b0;
        test_reset();
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; instr_i = '0;
        tick(); tick();
        rst_i = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_random_stream();
        test_flush();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
